led_fx_sched: RTL and testbench

Four-channel LED effect scheduler driving a single shared 8-bit PWM timebase. A valid/ready command port sets each channel's mode and target brightness. A step engine then ramps or breathes per-channel duty and loads glitch-free shadow duties at every PWM period boundary. It sits between board-level control (buttons, UART command decoder) and the LED pins, replacing per-LED free-running PWM/breathing counters.

---
 rtl/led_fx_sched.sv | 216 +++++++++++++++++++++
 tb/tb_led_fx_sched.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fx_sched.sv
// -----------------------------------------------------------------------------
// led_fx_sched
//
// Four-channel LED effect scheduler sharing one 8-bit PWM timebase.
// A valid/ready command port sets each channel's mode (OFF / STATIC / FADE /
// BREATHE) and its target or peak duty. A prescaled step tick drives the
// per-channel fade and breathe ramps. Working duties are copied into shadow
// registers only at the PWM wrap, so a period never mixes two duty values.
//
// Build option:
//   LED_FX_SCHED_GAMMA_EN  - when defined, the shadow load applies
//                            f(d) = (d*d + 255) >> 8 for perceptually even
//                            fades. Otherwise f(d) = d and no multiplier is
//                            built. Latency is the same in both builds.
//
// Parameters:
//   PWM_MAX   - last PWM count; the period is PWM_MAX+1 clocks
//   TICK_DIV  - clocks per step tick (2 .. 2^20-1)
//
// Ports:
//   sys_clk     in   clock, all logic on the rising edge
//   sys_rst     in   synchronous active-high reset
//   cmd_valid   in   command present (source holds it until accepted)
//   cmd_ready   out  command accepted on an edge where valid && ready
//   cmd_chan    in   [1:0] target channel
//   cmd_mode    in   [1:0] 0 OFF, 1 STATIC, 2 FADE, 3 BREATHE
//   cmd_target  in   [7:0] target / peak duty
//   led         out  [3:0] registered PWM outputs, active-high
//   fade_done   out  [3:0] one-cycle pulse when a FADE reaches its target
// -----------------------------------------------------------------------------
module led_fx_sched #(
    parameter logic [7:0]  PWM_MAX  = 8'd254,
    parameter logic [19:0] TICK_DIV = 20'd10_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_chan,
    input  logic [1:0] cmd_mode,
    input  logic [7:0] cmd_target,
    output logic [3:0] led,
    output logic [3:0] fade_done
);

    localparam int NCH = 4;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_FADE    = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [19:0]           presc_q,     presc_d;
    logic                  tick_q,      tick_d;
    logic [7:0]            pwm_cnt_q,   pwm_cnt_d;
    mode_e [NCH-1:0]       mode_q,      mode_d;
    logic  [NCH-1:0][7:0]  target_q,    target_d;
    logic  [NCH-1:0][7:0]  duty_q,      duty_d;
    logic  [NCH-1:0][7:0]  shadow_q,    shadow_d;
    logic  [NCH-1:0]       dir_q,       dir_d;
    logic  [NCH-1:0]       fade_done_q, fade_done_d;
    logic  [NCH-1:0]       led_q,       led_d;

    logic                  wrap;
    logic                  cmd_fire;

    // Duty shaping applied at the shadow load.
    function automatic logic [7:0] shape(input logic [7:0] d);
`ifdef LED_FX_SCHED_GAMMA_EN
        // 255*255 + 255 = 65280 still fits in 16 bits, so no overflow.
        return 8'(({8'd0, d} * {8'd0, d} + 16'd255) >> 8);
`else
        return d;
`endif
    endfunction

    // Ready drops on tick cycles so a command never races the step engine.
    assign cmd_ready = !sys_rst && !tick_q;
    assign cmd_fire  = cmd_valid && cmd_ready;

    assign wrap      = (pwm_cnt_q == PWM_MAX);

    assign led       = led_q;
    assign fade_done = fade_done_q;

    // -------------------------------------------------------------------------
    // Prescaler and PWM timebase
    // -------------------------------------------------------------------------
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first; a path that skips an assignment would infer a latch.
    always_comb begin
        presc_d   = presc_q + 20'd1;
        tick_d    = 1'b0;
        pwm_cnt_d = pwm_cnt_q + 8'd1;

        if (presc_q == TICK_DIV - 20'd1) begin
            presc_d = '0;
            tick_d  = 1'b1;
        end

        if (wrap) begin
            pwm_cnt_d = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Command accept, step engine, shadow load and output compare
    // -------------------------------------------------------------------------
    always_comb begin
        mode_d      = mode_q;
        target_d    = target_q;
        duty_d      = duty_q;
        dir_d       = dir_q;
        shadow_d    = shadow_q;
        fade_done_d = '0;
        led_d       = '0;

        for (int ch = 0; ch < NCH; ch++) begin
            if (cmd_fire && (cmd_chan == 2'(ch))) begin
                mode_d[ch]   = mode_e'(cmd_mode);
                target_d[ch] = cmd_target;
                unique case (mode_e'(cmd_mode))
                    MODE_OFF:     duty_d[ch] = 8'd0;
                    MODE_STATIC:  duty_d[ch] = cmd_target;
                    MODE_FADE:    ;                 // ramps from current duty
                    MODE_BREATHE: dir_d[ch]  = 1'b1;
                    default:      ;
                endcase
            end else if (tick_q) begin
                unique case (mode_q[ch])
                    MODE_FADE: begin
                        if (duty_q[ch] < target_q[ch]) begin
                            duty_d[ch] = duty_q[ch] + 8'd1;
                        end else if (duty_q[ch] > target_q[ch]) begin
                            duty_d[ch] = duty_q[ch] - 8'd1;
                        end else begin
                            // Arrived on an earlier tick: report and park.
                            fade_done_d[ch] = 1'b1;
                            mode_d[ch]      = MODE_STATIC;
                        end
                    end
                    MODE_BREATHE: begin
                        if (dir_q[ch]) begin
                            if (duty_q[ch] < target_q[ch]) begin
                                duty_d[ch] = duty_q[ch] + 8'd1;
                                // Turn around on the step that reaches the peak.
                                if (duty_q[ch] + 8'd1 == target_q[ch]) begin
                                    dir_d[ch] = 1'b0;
                                end
                            end else begin
                                // At or above the peak (peak lowered, or
                                // peak 0): turn around without moving.
                                dir_d[ch] = 1'b0;
                            end
                        end else begin
                            if (duty_q[ch] != 8'd0) begin
                                duty_d[ch] = duty_q[ch] - 8'd1;
                                if (duty_q[ch] == 8'd1) begin
                                    dir_d[ch] = 1'b1;
                                end
                            end else begin
                                dir_d[ch] = 1'b1;
                            end
                        end
                    end
                    default: ;                      // OFF, STATIC ignore ticks
                endcase
            end

            // Shadow samples the pre-command duty if a command lands on the
            // wrap edge; the new duty shows one period later.
            if (wrap) begin
                shadow_d[ch] = shape(duty_q[ch]);
            end

            led_d[ch] = ({1'b0, pwm_cnt_q} < {1'b0, shadow_q[ch]});
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: reset is synchronous and clears every register, including the
    // per-channel arrays, so a reset mid-fade leaves no stale duty behind.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            presc_q     <= '0;
            tick_q      <= 1'b0;
            pwm_cnt_q   <= '0;
            mode_q      <= {NCH{MODE_OFF}};
            target_q    <= '0;
            duty_q      <= '0;
            shadow_q    <= '0;
            dir_q       <= '1;
            fade_done_q <= '0;
            led_q       <= '0;
        end else begin
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            pwm_cnt_q   <= pwm_cnt_d;
            mode_q      <= mode_d;
            target_q    <= target_d;
            duty_q      <= duty_d;
            shadow_q    <= shadow_d;
            dir_q       <= dir_d;
            fade_done_q <= fade_done_d;
            led_q       <= led_d;
        end
    end

endmodule

// File: tb/tb_led_fx_sched.sv
// -----------------------------------------------------------------------------
// tb_led_fx_sched
//
// Directed bench for led_fx_sched with TICK_DIV=4 and PWM_MAX=254. Each
// scenario task drives its own stimulus and compares against hand-computed
// values. Step-engine duty and mode are observed hierarchically; tick cycles
// are recognised from cmd_ready going low. Outputs are sampled on the falling
// edge or 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_led_fx_sched;

    localparam logic [7:0]  PWM_MAX  = 8'd254;
    localparam logic [19:0] TICK_DIV = 20'd4;
    localparam int          PERIOD   = 255;

    localparam logic [1:0] M_OFF     = 2'd0;
    localparam logic [1:0] M_STATIC  = 2'd1;
    localparam logic [1:0] M_FADE    = 2'd2;
    localparam logic [1:0] M_BREATHE = 2'd3;

    logic       sys_clk    = 1'b0;
    logic       sys_rst    = 1'b1;
    logic       cmd_valid  = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_chan   = 2'd0;
    logic [1:0] cmd_mode   = 2'd0;
    logic [7:0] cmd_target = 8'd0;
    logic [3:0] led;
    logic [3:0] fade_done;

    int n_cmp   = 0;
    int n_bad   = 0;
    int acc_cnt = 0;

    led_fx_sched #(
        .PWM_MAX  (PWM_MAX),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_chan   (cmd_chan),
        .cmd_mode   (cmd_mode),
        .cmd_target (cmd_target),
        .led        (led),
        .fade_done  (fade_done)
    );

    always #5 sys_clk = ~sys_clk;

    // Counts handshakes so a held command can be shown to land exactly once.
    always @(posedge sys_clk) begin
        if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected shadow value for a given duty.
    function automatic int exp_shadow(input int d);
`ifdef LED_FX_SCHED_GAMMA_EN
        return (d * d + 255) >> 8;
`else
        return d;
`endif
    endfunction

    // Present a command and hold it until accepted; returns 1 after the
    // accepting edge (+1 time unit).
    task automatic send_cmd(input logic [1:0] ch, input logic [1:0] mode,
                            input logic [7:0] tgt);
        bit sent;
        sent       = 1'b0;
        cmd_chan   = ch;
        cmd_mode   = mode;
        cmd_target = tgt;
        cmd_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                @(posedge sys_clk);
                #1;
                sent = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        cmd_valid = 1'b0;
        if (!sent) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_cmd: command ch%0d not accepted within 20 cycles", ch);
        end
    endtask

    // Advance to a cycle in which the step tick is active (cmd_ready low).
    task automatic wait_tick(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!cmd_ready) begin
                found = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no tick within 20 cycles", name);
        end
    endtask

    // Advance through the next step edge, leaving time just after it.
    task automatic step_tick(input string name);
        wait_tick(name);
        @(posedge sys_clk);
        #1;
    endtask

    // Count high samples of led[ch] and of the other channels over one period.
    task automatic count_period(input int ch, output int n_hi, output int n_other);
        n_hi    = 0;
        n_other = 0;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge sys_clk);
            if (led[ch] === 1'b1) n_hi++;
            for (int k = 0; k < 4; k++) begin
                if (k != ch && led[k] !== 1'b0) n_other++;
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        n_cmp++;
        if (led !== 4'b0000) begin
            n_bad++; $display("FAIL reset_led: got %b expected 0000", led);
        end
        n_cmp++;
        if (fade_done !== 4'b0000) begin
            n_bad++; $display("FAIL reset_fade_done: got %b expected 0000", fade_done);
        end
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_ready: got %b expected 0", cmd_ready);
        end
        sys_rst = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL release_ready: got %b expected 1", cmd_ready);
        end
        n_cmp++;
        if (dut.pwm_cnt_q !== 8'd0 || dut.presc_q !== 20'd0) begin
            n_bad++;
            $display("FAIL release_counters: got pwm %0d presc %0d expected 0 0",
                     dut.pwm_cnt_q, dut.presc_q);
        end
        n_cmp++;
        if (dut.duty_q !== '0 || dut.dir_q !== 4'b1111) begin
            n_bad++;
            $display("FAIL release_state: got duty %h dir %b expected 0 1111",
                     dut.duty_q, dut.dir_q);
        end
    endtask

    task automatic test_static();
        int n_hi, n_other;
        send_cmd(2'd0, M_STATIC, 8'd64);
        n_cmp++;
        if (dut.duty_q[0] !== 8'd64) begin
            n_bad++; $display("FAIL static_duty: got %0d expected 64", dut.duty_q[0]);
        end
        repeat (2 * PERIOD) @(negedge sys_clk);
        count_period(0, n_hi, n_other);
        n_cmp++;
        if (n_hi != exp_shadow(64)) begin
            n_bad++; $display("FAIL static_high_count: got %0d expected %0d", n_hi, exp_shadow(64));
        end
        n_cmp++;
        if (n_other != 0) begin
            n_bad++; $display("FAIL static_other_leds: got %0d high samples expected 0", n_other);
        end
    endtask

    task automatic test_pwm_bounds();
        int n_hi, n_other;
        send_cmd(2'd0, M_STATIC, 8'd255);
        repeat (2 * PERIOD) @(negedge sys_clk);
        count_period(0, n_hi, n_other);
        n_cmp++;
        if (n_hi != PERIOD) begin
            n_bad++; $display("FAIL full_duty: got %0d expected %0d", n_hi, PERIOD);
        end
        send_cmd(2'd0, M_STATIC, 8'd0);
        repeat (2 * PERIOD) @(negedge sys_clk);
        count_period(0, n_hi, n_other);
        n_cmp++;
        if (n_hi != 0) begin
            n_bad++; $display("FAIL zero_duty: got %0d expected 0", n_hi);
        end
    endtask

    task automatic test_fade();
        send_cmd(2'd1, M_FADE, 8'd3);
        for (int k = 1; k <= 3; k++) begin
            step_tick("fade_step");
            n_cmp++;
            if (dut.duty_q[1] !== 8'(k) || fade_done !== 4'b0000) begin
                n_bad++;
                $display("FAIL fade_step%0d: got duty %0d done %b expected %0d 0000",
                         k, dut.duty_q[1], fade_done, k);
            end
        end
        step_tick("fade_done");
        n_cmp++;
        if (fade_done !== 4'b0010 || dut.duty_q[1] !== 8'd3) begin
            n_bad++;
            $display("FAIL fade_done_pulse: got done %b duty %0d expected 0010 3",
                     fade_done, dut.duty_q[1]);
        end
        n_cmp++;
        if (dut.mode_q[1] !== M_STATIC) begin
            n_bad++; $display("FAIL fade_mode: got %0d expected %0d", dut.mode_q[1], M_STATIC);
        end
        @(posedge sys_clk);
        #1;
        n_cmp++;
        if (fade_done !== 4'b0000) begin
            n_bad++; $display("FAIL fade_done_width: got %b expected 0000", fade_done);
        end
    endtask

    task automatic test_fade_reissue();
        logic [7:0] exp_seq [5];
        exp_seq = '{8'd4, 8'd5, 8'd4, 8'd3, 8'd2};
        send_cmd(2'd1, M_FADE, 8'd8);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) send_cmd(2'd1, M_FADE, 8'd2);
            step_tick("reissue_step");
            n_cmp++;
            if (dut.duty_q[1] !== exp_seq[k] || fade_done !== 4'b0000) begin
                n_bad++;
                $display("FAIL reissue_step%0d: got duty %0d done %b expected %0d 0000",
                         k, dut.duty_q[1], fade_done, exp_seq[k]);
            end
        end
        step_tick("reissue_done");
        n_cmp++;
        if (fade_done !== 4'b0010 || dut.mode_q[1] !== M_STATIC) begin
            n_bad++;
            $display("FAIL reissue_done: got done %b mode %0d expected 0010 %0d",
                     fade_done, dut.mode_q[1], M_STATIC);
        end
    endtask

    task automatic test_breathe();
        logic [7:0] exp_seq [8];
        exp_seq = '{8'd1, 8'd2, 8'd1, 8'd0, 8'd1, 8'd2, 8'd1, 8'd0};
        send_cmd(2'd2, M_BREATHE, 8'd2);
        for (int k = 0; k < 8; k++) begin
            step_tick("breathe_step");
            n_cmp++;
            if (dut.duty_q[2] !== exp_seq[k]) begin
                n_bad++;
                $display("FAIL breathe_step%0d: got %0d expected %0d",
                         k, dut.duty_q[2], exp_seq[k]);
            end
        end
    endtask

    task automatic test_back_to_back_holdoff();
        int acc0;
        @(posedge sys_clk);
        #1;
        wait_tick("holdoff_tick");
        acc0       = acc_cnt;
        cmd_chan   = 2'd3;
        cmd_mode   = M_STATIC;
        cmd_target = 8'd200;
        cmd_valid  = 1'b1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_bad++; $display("FAIL holdoff_ready: got %b expected 0", cmd_ready);
        end
        @(posedge sys_clk);
        #1;
        n_cmp++;
        if (dut.mode_q[3] !== M_OFF || cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL holdoff_not_taken: got mode %0d ready %b expected %0d 1",
                     dut.mode_q[3], cmd_ready, M_OFF);
        end
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
        n_cmp++;
        if (dut.duty_q[3] !== 8'd200 || dut.mode_q[3] !== M_STATIC) begin
            n_bad++;
            $display("FAIL holdoff_taken: got duty %0d mode %0d expected 200 %0d",
                     dut.duty_q[3], dut.mode_q[3], M_STATIC);
        end
        repeat (3) @(posedge sys_clk);
        #1;
        n_cmp++;
        if (acc_cnt - acc0 != 1) begin
            n_bad++; $display("FAIL holdoff_once: got %0d accepts expected 1", acc_cnt - acc0);
        end
    endtask

    task automatic test_gamma();
        int n_hi, n_other;
        send_cmd(2'd0, M_STATIC, 8'd128);
        repeat (2 * PERIOD) @(negedge sys_clk);
        count_period(0, n_hi, n_other);
        n_cmp++;
        if (n_hi != exp_shadow(128)) begin
            n_bad++; $display("FAIL gamma_128: got %0d expected %0d", n_hi, exp_shadow(128));
        end
    endtask

    task automatic test_reset_mid_fade();
        int n_hi, n_other;
        send_cmd(2'd0, M_FADE, 8'd250);
        step_tick("midfade_step");
        step_tick("midfade_step");
        n_cmp++;
        if (dut.duty_q[0] !== 8'd130) begin
            n_bad++; $display("FAIL midfade_ramp: got %0d expected 130", dut.duty_q[0]);
        end
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        n_cmp++;
        if (led !== 4'b0000 || fade_done !== 4'b0000 || cmd_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got led %b done %b ready %b expected 0000 0000 0",
                     led, fade_done, cmd_ready);
        end
        n_cmp++;
        if (dut.duty_q !== '0 || dut.shadow_q !== '0 || dut.mode_q !== '0 ||
            dut.target_q !== '0 || dut.dir_q !== 4'b1111) begin
            n_bad++;
            $display("FAIL midreset_state: got duty %h shadow %h mode %h target %h dir %b",
                     dut.duty_q, dut.shadow_q, dut.mode_q, dut.target_q, dut.dir_q);
        end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        count_period(0, n_hi, n_other);
        n_cmp++;
        if (n_hi != 0 || n_other != 0) begin
            n_bad++;
            $display("FAIL post_reset_dark: got %0d/%0d high samples expected 0/0", n_hi, n_other);
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_pwm_bounds();
        test_fade();
        test_fade_reissue();
        test_breathe();
        test_back_to_back_holdoff();
        test_gamma();
        test_reset_mid_fade();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
